// File: rtl/bitnet_pipe_dual_tree_acc.sv
`default_nettype none
// ============================================================================
// Module   : bitnet_pipe_dual_tree_acc
// Brief    : Pipelined ternary-weighted dual (pos/neg) adder tree with a
//            signed packet accumulator, optional saturation and a sticky
//            overflow flag, presented on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module bitnet_pipe_dual_tree_acc #(
    parameter int N_IN  = 8,
    parameter int IN_W  = 16,
    parameter int OUT_W = 24,
    parameter bit SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*IN_W-1:0]    in_vec,
    input  logic [N_IN-1:0]         sign_vec,
    input  logic [N_IN-1:0]         zero_vec,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_ovf,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int c_LVLS  = $clog2(N_IN);
    localparam int c_TW    = IN_W + 1 + c_LVLS;
    localparam int c_NODES = 2 * N_IN - 1;
    localparam int c_LEAF0 = N_IN - 1;
    localparam logic signed [OUT_W-1:0] c_ACC_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_ACC_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Heap-ordered trees: node i has children 2i+1 / 2i+2, leaves start at
    // c_LEAF0. Every node depth is one pipeline stage, so the root lands in
    // stage L and the positive/negative difference adds one more register.
    logic signed [c_TW-1:0]  pos_q [c_NODES];
    logic signed [c_TW-1:0]  neg_q [c_NODES];
    logic signed [c_TW-1:0]  diff_q;
    logic signed [c_TW-1:0]  lane_x [N_IN];
    logic [c_LVLS:0]         tv_q;
    logic [c_LVLS:0]         tl_q;
    logic                    dv_q;
    logic                    dl_q;

    logic signed [OUT_W-1:0] acc_q;
    logic                    sticky_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_ovf_q;
    logic                    out_valid_q;

    logic                    advance;
    logic signed [OUT_W:0]   acc_sum_d;
    logic                    acc_ovf_d;
    logic signed [OUT_W-1:0] acc_d;

    // Whole pipeline freezes only while a result waits to be consumed.
    assign advance   = !(out_valid_q && !out_ready);
    assign in_ready  = advance;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

    // Sign-extend each lane to tree width so negating the most negative value is exact.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            lane_x[k] = c_TW'($signed(in_vec[k*IN_W +: IN_W]));
        end
    end

    // Valid/last shift chain shadowing the tree stages and the difference stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv_q <= '0;
            tl_q <= '0;
            dv_q <= 1'b0;
            dl_q <= 1'b0;
        end else if (advance) begin
            tv_q <= {tv_q[c_LVLS-1:0], in_valid};
            tl_q <= {tl_q[c_LVLS-1:0], in_valid & in_last};
            dv_q <= tv_q[c_LVLS];
            dl_q <= tl_q[c_LVLS];
        end
    end

    // Datapath: split lanes into pos/neg leaves, reduce both trees, take the difference.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < N_IN; k++) begin
                pos_q[c_LEAF0+k] <= (!zero_vec[k] && !sign_vec[k]) ? lane_x[k] : '0;
                neg_q[c_LEAF0+k] <= (!zero_vec[k] &&  sign_vec[k]) ? lane_x[k] : '0;
            end
            for (int i = 0; i < c_LEAF0; i++) begin
                pos_q[i] <= pos_q[2*i+1] + pos_q[2*i+2];
                neg_q[i] <= neg_q[2*i+1] + neg_q[2*i+2];
            end
            diff_q <= pos_q[0] - neg_q[0];
        end
    end

    // One guard bit catches overflow; clamp or wrap back to OUT_W.
    always_comb begin
        acc_sum_d = (OUT_W+1)'(acc_q) + (OUT_W+1)'(diff_q);
        acc_ovf_d = acc_sum_d[OUT_W] ^ acc_sum_d[OUT_W-1];
        acc_d     = acc_sum_d[OUT_W-1:0];
        if (SAT && acc_ovf_d) begin
            acc_d = acc_sum_d[OUT_W] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    // Accumulate beats; a last beat publishes the result and restarts the packet cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            // Advancing implies any pending result was taken this cycle.
            out_valid_q <= dv_q && dl_q;
            if (dv_q) begin
                if (dl_q) begin
                    out_data_q <= acc_d;
                    out_ovf_q  <= sticky_q | acc_ovf_d;
                    acc_q      <= '0;
                    sticky_q   <= 1'b0;
                end else begin
                    acc_q      <= acc_d;
                    sticky_q   <= sticky_q | acc_ovf_d;
                end
            end
        end
    end

endmodule
`default_nettype wire
